// File: rtl/vector_serializer_pkg.sv
// Shared types and helpers for the vector serializer: lane index width,
// lane slice offset and the shifter state encoding.
package vector_serializer_pkg;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        SHIFT = 1'b1
    } shift_state_e;

    function automatic int calc_lane_bits(input int lanes);
        return $clog2(lanes);
    endfunction

    function automatic int lane_lsb(input int lane, input int word_width);
        return lane * word_width;
    endfunction

endpackage

// File: rtl/vector_hold_buffer.sv
// One-entry registered vector buffer with a full flag. A load takes priority
// over an unload so a same-cycle refill keeps the buffer full.
module vector_hold_buffer
    import vector_serializer_pkg::*;
#(
    parameter int WIDTH = 288
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             unload,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full
);

    logic [WIDTH-1:0] data_r;
    logic             full_r;

    // Buffer storage and occupancy flag
    always_ff @(posedge clock) begin
        if (reset) begin
            data_r <= {WIDTH{1'b0}};
            full_r <= 1'b0;
        end else if (load) begin
            data_r <= data_in;
            full_r <= 1'b1;
        end else if (unload) begin
            full_r <= 1'b0;
        end else begin
            full_r <= full_r;
        end
    end

    assign data_out = data_r;
    assign full     = full_r;

endmodule

// File: rtl/vector_serializer.sv
// Packed-vector to word-stream serializer: a shifter presents lane 0 first,
// and a hold buffer keeps the next vector so vectors stream without gaps.
module vector_serializer
    import vector_serializer_pkg::*;
#(
    parameter int WORD_WIDTH = 36,
    parameter int LANES      = 8,
    parameter int LANE_BITS  = calc_lane_bits(LANES)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*WORD_WIDTH-1:0] in_vector,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WORD_WIDTH-1:0]       out_word,
    output logic [LANE_BITS-1:0]        out_lane,
    output logic                        out_last
);

    localparam int VEC_W = LANES * WORD_WIDTH;
    localparam logic [LANE_BITS-1:0] LAST_LANE = LANE_BITS'(LANES - 1);

    shift_state_e         state_r, state_s;
    logic [VEC_W-1:0]     data_r, data_s;
    logic [LANE_BITS-1:0] lane_r, lane_s;
    logic                 last_r;

    logic [VEC_W-1:0]     hold_data_s;
    logic                 hold_full_s;
    logic                 hold_load_s;
    logic                 hold_unload_s;
    logic                 accept_s;
    logic                 handshake_s;

    assign in_ready    = !hold_full_s && !reset;
    assign accept_s    = in_valid && in_ready;
    assign out_valid   = (state_r == SHIFT);
    assign handshake_s = out_valid && out_ready;
    assign out_word    = data_r[lane_lsb(0, WORD_WIDTH) +: WORD_WIDTH];
    assign out_lane    = lane_r;
    assign out_last    = last_r;

    vector_hold_buffer #(
        .WIDTH (VEC_W)
    ) u_hold (
        .clock    (clock),
        .reset    (reset),
        .load     (hold_load_s),
        .unload   (hold_unload_s),
        .data_in  (in_vector),
        .data_out (hold_data_s),
        .full     (hold_full_s)
    );

    // Shifter next state and steering of accepted vectors
    always_comb begin
        state_s       = state_r;
        data_s        = data_r;
        lane_s        = lane_r;
        hold_load_s   = 1'b0;
        hold_unload_s = 1'b0;
        case (state_r)
            EMPTY: begin
                if (hold_full_s) begin
                    state_s       = SHIFT;
                    data_s        = hold_data_s;
                    lane_s        = {LANE_BITS{1'b0}};
                    hold_unload_s = 1'b1;
                end else if (accept_s) begin
                    state_s = SHIFT;
                    data_s  = in_vector;
                    lane_s  = {LANE_BITS{1'b0}};
                end else begin
                    state_s = EMPTY;
                end
            end
            SHIFT: begin
                if (handshake_s && (lane_r != LAST_LANE)) begin
                    data_s      = {{WORD_WIDTH{1'b0}}, data_r[VEC_W-1:lane_lsb(1, WORD_WIDTH)]};
                    lane_s      = lane_r + LANE_BITS'(1);
                    hold_load_s = accept_s;
                end else if (handshake_s) begin
                    // Last lane leaves: reload from hold first, then the input.
                    lane_s = {LANE_BITS{1'b0}};
                    if (hold_full_s) begin
                        data_s        = hold_data_s;
                        hold_unload_s = 1'b1;
                    end else if (accept_s) begin
                        data_s = in_vector;
                    end else begin
                        state_s = EMPTY;
                    end
                end else begin
                    hold_load_s = accept_s;
                end
            end
            default: begin
                state_s = EMPTY;
                lane_s  = {LANE_BITS{1'b0}};
            end
        endcase
    end

    // Shifter, lane counter and last-lane flag registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= EMPTY;
            data_r  <= {VEC_W{1'b0}};
            lane_r  <= {LANE_BITS{1'b0}};
            last_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            data_r  <= data_s;
            lane_r  <= lane_s;
            last_r  <= (state_s == SHIFT) && (lane_s == LAST_LANE);
        end
    end

endmodule

// File: tb/tb_vector_serializer.sv
// Scoreboard bench for vector_serializer: accepted vectors are expanded into
// expected words, and a monitor compares every output handshake in order.
module tb_vector_serializer;

    localparam int W  = 36;
    localparam int L  = 8;
    localparam int LB = 3;

    typedef struct packed {
        logic [LB-1:0] lane;
        logic          last;
        logic [W-1:0]  word;
    } exp_t;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [L*W-1:0] in_vector = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [W-1:0]   out_word;
    logic [LB-1:0]  out_lane;
    logic           out_last;

    int   checks   = 0;
    int   errors   = 0;
    int   words_rx = 0;
    exp_t sb[$];

    vector_serializer #(
        .WORD_WIDTH (W),
        .LANES      (L)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vector (in_vector),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_lane  (out_lane),
        .out_last  (out_last)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [L*W-1:0] make_vec(input logic [W-1:0] base);
        logic [L*W-1:0] v;
        for (int i = 0; i < L; i++) v[i*W +: W] = base + W'(i);
        return v;
    endfunction

    // Expected words of every accepted vector, lane 0 first
    always @(negedge clock) begin : sb_push
        exp_t e;
        if (!reset && in_valid && in_ready) begin
            for (int i = 0; i < L; i++) begin
                e.lane = LB'(i);
                e.last = (i == L - 1);
                e.word = in_vector[i*W +: W];
                sb.push_back(e);
            end
        end
    end

    always @(posedge clock) begin
        if (reset) sb.delete();
    end

    // Compare each word the consumer takes against the scoreboard head
    always @(negedge clock) begin : sb_mon
        exp_t e;
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_unexpected actual lane=%0d word=%0h required=no word", out_lane, out_word);
            end else begin
                e = sb.pop_front();
                check("out_beat", {out_lane, out_last, out_word}, {e.lane, e.last, e.word});
                words_rx++;
            end
        end
    end

    task automatic send_vec(input logic [L*W-1:0] v);
        int n;
        n = 0;
        in_vector = v;
        in_valid  = 1'b1;
        @(negedge clock);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clock);
        end
        check("send_accept", in_ready, 1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 2000) begin
            @(negedge clock);
            n++;
        end
        check(name, {sb.size() == 0, out_valid}, {1'b1, 1'b0});
        @(posedge clock);
        #1;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  n, cnt, acc, cyc, cyc2;
        bit  saw_low, prod_done, pending;
        logic [63:0]    r;
        logic [L*W-1:0] v;

        // Reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_word", out_word, 0);
        check("rst_out_lane", out_lane, 0);
        check("rst_out_last", out_last, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_in_ready", in_ready, 1);

        // Single vector, one-cycle latency, then idle with word held
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        send_vec(make_vec(36'h10));
        @(negedge clock);
        check("lat_valid", out_valid, 1);
        check("lat_lane", out_lane, 0);
        check("lat_word", out_word, 36'h10);
        repeat (7) @(negedge clock);
        @(negedge clock);
        check("idle_valid", out_valid, 0);
        check("idle_word_held", out_word, 36'h17);
        check("idle_lane", out_lane, 0);
        check("idle_last", out_last, 0);
        @(posedge clock);
        #1;

        // Streaming three vectors without gaps
        cnt = 0;
        n = 0;
        saw_low = 1'b0;
        fork
            begin
                send_vec(make_vec(36'h100));
                send_vec(make_vec(36'h200));
                send_vec(make_vec(36'h300));
            end
            begin
                do begin
                    @(negedge clock);
                    n++;
                end while (!out_valid && n < 20);
                cnt = out_valid ? 1 : 0;
                repeat (23) begin
                    @(negedge clock);
                    if (out_valid) cnt++;
                    if (!in_ready) saw_low = 1'b1;
                end
                check("stream_count", cnt, 24);
                check("stream_hold_full_seen", saw_low, 1);
                @(negedge clock);
                check("stream_end_idle", out_valid, 0);
            end
        join
        drain("stream_drain");

        // Backpressure at lane 3
        send_vec(make_vec(36'h10));
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!(out_valid && out_lane == 3'd2) && n < 50);
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        repeat (5) begin
            @(negedge clock);
            check("bp_word", out_word, 36'h13);
            check("bp_lane", out_lane, 3);
        end
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check("bp_resume_word", out_word, 36'h14);
        check("bp_resume_lane", out_lane, 4);
        drain("bp_drain");

        // Full stall: shifter busy and hold full block a third vector
        out_ready = 1'b0;
        send_vec(make_vec(36'h20));
        send_vec(make_vec(36'h30));
        in_vector = make_vec(36'h60);
        in_valid  = 1'b1;
        @(negedge clock);
        check("stall_in_ready", in_ready, 0);
        @(negedge clock);
        check("stall_in_ready2", in_ready, 0);
        check("stall_word", out_word, 36'h20);
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!(out_valid && out_last) && n < 50);
        check("stall_last_in_ready", in_ready, 0);
        @(negedge clock);
        check("stall_release_in_ready", in_ready, 1);
        check("stall_reload_word", out_word, 36'h30);
        check("stall_reload_lane", out_lane, 0);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        @(negedge clock);
        check("stall_third_in_hold", in_ready, 0);
        drain("stall_drain");

        // Reset at lane 4 with hold full
        send_vec(make_vec(36'h40));
        send_vec(make_vec(36'h50));
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!(out_valid && out_lane == 3'd4) && n < 50);
        check("mid_rst_hold_full", in_ready, 0);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_word", out_word, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_lane", out_lane, 0);
        @(posedge clock);
        #1;
        send_vec(make_vec(36'hA0));
        @(negedge clock);
        check("after_rst_word", out_word, 36'hA0);
        check("after_rst_lane", out_lane, 0);
        drain("after_rst_drain");

        // Random valid/ready over 1000 vectors
        words_rx  = 0;
        acc       = 0;
        cyc       = 0;
        cyc2      = 0;
        prod_done = 1'b0;
        pending   = 1'b0;
        fork
            begin
                while (acc < 1000 && cyc < 30000) begin
                    if (!pending) begin
                        for (int i = 0; i < L; i++) begin
                            r = {$urandom(), $urandom()};
                            v[i*W +: W] = r[W-1:0];
                        end
                        pending = 1'b1;
                    end
                    in_vector = v;
                    in_valid  = 1'($urandom_range(0, 1));
                    @(negedge clock);
                    if (in_valid && in_ready) begin
                        acc++;
                        pending = 1'b0;
                    end
                    @(posedge clock);
                    #1;
                    cyc++;
                end
                in_valid  = 1'b0;
                prod_done = 1'b1;
            end
            begin
                while (!(prod_done && sb.size() == 0 && !out_valid) && cyc2 < 30000) begin
                    out_ready = 1'($urandom_range(0, 1));
                    @(posedge clock);
                    #1;
                    cyc2++;
                end
                out_ready = 1'b1;
            end
        join
        check("rand_accepted", acc, 1000);
        check("rand_words", words_rx, 8000);
        drain("rand_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
